// File: rtl/match_burst_fsm_if.sv
// Beat/handshake bundle between a burst source/sink and match_burst_fsm.
interface match_burst_fsm_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 4
);
  logic              valid;
  logic [DATA_W-1:0] seq;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] mask;
  logic              mode;
  logic              abort;
  logic              hit;
  logic              hit_ready;
  logic [CNT_W-1:0]  hit_count;
  logic              sat;
  logic              drop;

  // Block side
  modport slave (
    input  valid, seq, pattern, mask, mode, abort, hit_ready,
    output hit, hit_count, sat, drop
  );

  // Source/sink side
  modport master (
    output valid, seq, pattern, mask, mode, abort, hit_ready,
    input  hit, hit_count, sat, drop
  );
endinterface

// File: rtl/match_burst_fsm.sv
// Counts masked pattern matches during a valid burst, then reports the count
// downstream either as one hit per match (train) or one hit with the total (summary).
module match_burst_fsm #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  match_burst_fsm_if.slave     bus,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     cnt,
  output logic [CNT_W-1:0]     n_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WATCH = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       n_state;
  logic [CNT_W-1:0] cnt_nx;
  logic             match;
  logic             mode_q;
  logic             n_mode;
  logic             sat_q;
  logic             n_sat;
  logic             hit_q;
  logic [CNT_W-1:0] hit_count_q;
  logic             drop_c;

  // Masked compare; an all-zero mask matches every valid beat
  always_comb begin
    match = bus.valid && (((bus.seq ^ bus.pattern) & bus.mask) == '0);
  end

  // Next-state, next-count, sticky saturation and drop decode
  always_comb begin
    n_state = state;
    cnt_nx  = cnt;
    n_sat   = sat_q;
    n_mode  = mode_q;
    drop_c  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.valid) begin
          n_state = WATCH;
          n_mode  = bus.mode;
          if (match) cnt_nx = CNT_ONE;
        end
      end
      WATCH: begin
        if (bus.valid) begin
          if (match) begin
            if (cnt == CNT_MAX) n_sat  = 1'b1;
            else                cnt_nx = cnt + CNT_ONE;
          end
        end else if (cnt != '0) begin
          n_state = EMIT;
        end else begin
          n_state = IDLE;
        end
      end
      EMIT: begin
        drop_c = bus.valid;
        if (bus.hit_ready) begin
          if (mode_q || cnt == CNT_ONE) begin
            n_state = IDLE;
            cnt_nx  = '0;
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
      end
      default: begin
        n_state = IDLE;
        cnt_nx  = '0;
      end
    endcase

    if (n_state == IDLE) n_sat = 1'b0;

    // Abort discards the burst without reporting anything
    if (bus.abort) begin
      n_state = IDLE;
      cnt_nx  = '0;
      n_sat   = 1'b0;
      n_mode  = mode_q;
      drop_c  = 1'b0;
    end
  end

  // State, counter and output registers; hit mirrors the EMIT state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sat_q       <= 1'b0;
      mode_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state       <= n_state;
      cnt         <= cnt_nx;
      sat_q       <= n_sat;
      mode_q      <= n_mode;
      hit_q       <= (n_state == EMIT);
      hit_count_q <= (n_state == EMIT) ? cnt_nx : '0;
    end
  end

  // Debug next-count view, held at zero while in reset
  always_comb begin
    n_cnt = reset ? '0 : cnt_nx;
  end

  assign bus.hit       = hit_q;
  assign bus.hit_count = hit_count_q;
  assign bus.sat       = sat_q;
  assign bus.drop      = drop_c;

endmodule

// File: tb/tb_match_burst_fsm.sv
// Directed vector bench for match_burst_fsm (DATA_W=4, CNT_W=4).
module tb_match_burst_fsm;

  logic       clock;
  logic       reset;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] n_cnt;

  int n_checks = 0;
  int n_errors = 0;

  match_burst_fsm_if #(.DATA_W(4), .CNT_W(4)) bus ();

  match_burst_fsm #(.DATA_W(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .state (state),
    .cnt   (cnt),
    .n_cnt (n_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [3:0] sq;
    logic [3:0] pt;
    logic [3:0] mk;
    logic       md;
    logic       ab;
    logic       hr;
    logic [1:0] e_st;
    logic [3:0] e_cnt;
    logic [3:0] e_ncnt;
    logic       e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input int v, input int sq, input int pt, input int mk,
                               input int md, input int ab, input int hr,
                               input int st, input int c, input int nc, input int dr);
    vec_t r;
    r.v = 1'(v);   r.sq = 4'(sq); r.pt = 4'(pt); r.mk = 4'(mk);
    r.md = 1'(md); r.ab = 1'(ab); r.hr = 1'(hr);
    r.e_st = 2'(st); r.e_cnt = 4'(c); r.e_ncnt = 4'(nc); r.e_drop = 1'(dr);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.valid = t.v;  bus.seq = t.sq;  bus.pattern = t.pt; bus.mask = t.mk;
    bus.mode  = t.md; bus.abort = t.ab; bus.hit_ready = t.hr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int hs;
    int exp_hit;
    int exp_hc;

    reset = 1'b1;
    bus.valid = 1'b0; bus.seq = '0; bus.pattern = '0; bus.mask = '0;
    bus.mode = 1'b0; bus.abort = 1'b0; bus.hit_ready = 1'b0;

    // Train burst A,3,A,A,1 (pattern A, mask F), mode flips after capture
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 0,0,1,0));
    tbl.push_back(row(1,'h3,'hA,'hF,1,0,0, 1,1,1,0));
    tbl.push_back(row(1,'hA,'hA,'hF,1,0,0, 1,1,2,0));
    tbl.push_back(row(1,'hA,'hA,'hF,1,0,0, 1,2,3,0));
    tbl.push_back(row(1,'h1,'hA,'hF,1,0,0, 1,3,3,0));
    tbl.push_back(row(0,'h0,'hA,'hF,1,0,1, 1,3,3,0));
    tbl.push_back(row(0,'h0,'hA,'hF,1,0,1, 2,3,2,0));
    tbl.push_back(row(0,'h0,'hA,'hF,1,0,1, 2,2,1,0));
    tbl.push_back(row(0,'h0,'hA,'hF,1,0,1, 2,1,0,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,1, 0,0,0,0));
    // Summary burst, hit_ready low 4 cycles
    tbl.push_back(row(1,'hA,'hA,'hF,1,0,0, 0,0,1,0));
    tbl.push_back(row(1,'h3,'hA,'hF,0,0,0, 1,1,1,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 1,1,2,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 1,2,3,0));
    tbl.push_back(row(1,'h1,'hA,'hF,0,0,0, 1,3,3,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 1,3,3,0));
    for (int i = 0; i < 4; i++) tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 2,3,3,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,1, 2,3,0,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,1, 0,0,0,0));
    // Zero-match burst goes straight back to IDLE
    tbl.push_back(row(1,'h0,'h5,'hF,0,0,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(row(1,'h0,'h5,'hF,0,0,0, 1,0,0,0));
    tbl.push_back(row(0,'h0,'h5,'hF,0,0,0, 1,0,0,0));
    tbl.push_back(row(0,'h0,'h5,'hF,0,0,0, 0,0,0,0));
    // Drops during EMIT, then back-to-back start, then abort in WATCH at cnt=2
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 0,0,1,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 1,1,2,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 1,2,2,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 2,2,2,1));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 2,2,2,1));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,1, 2,2,1,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,1, 2,1,0,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 0,0,1,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 1,1,2,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,1,0, 1,2,0,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 0,0,0,0));
    // Abort in EMIT with a valid beat: no drop, no further hit
    tbl.push_back(row(1,'hA,'hA,'hF,0,0,0, 0,0,1,0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 1,1,1,0));
    tbl.push_back(row(1,'hA,'hA,'hF,0,1,0, 2,1,0,1'b0));
    tbl.push_back(row(0,'h0,'hA,'hF,0,0,0, 0,0,0,0));
    // Partial mask 4'hC: only the top two bits are compared
    tbl.push_back(row(1,'h8,'hA,'hC,0,0,0, 0,0,1,0));
    tbl.push_back(row(1,'h4,'hA,'hC,0,0,0, 1,1,1,0));
    tbl.push_back(row(1,'hB,'hA,'hC,0,0,0, 1,1,2,0));
    tbl.push_back(row(0,'h0,'hA,'hC,0,0,1, 1,2,2,0));
    tbl.push_back(row(0,'h0,'hA,'hC,0,0,1, 2,2,1,0));
    tbl.push_back(row(0,'h0,'hA,'hC,0,0,1, 2,1,0,0));
    tbl.push_back(row(0,'h0,'hA,'hC,0,0,1, 0,0,0,0));

    // Reset state
    #12;
    chk("rst_state", 0, int'(state), 0);
    chk("rst_cnt",   0, int'(cnt), 0);
    chk("rst_ncnt",  0, int'(n_cnt), 0);
    chk("rst_hit",   0, int'(bus.hit), 0);
    chk("rst_hc",    0, int'(bus.hit_count), 0);
    chk("rst_sat",   0, int'(bus.sat), 0);
    chk("rst_drop",  0, int'(bus.drop), 0);
    reset = 1'b0;
    tick();

    // Table vectors: outputs checked in the same cycle as their inputs
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      exp_hit = (tbl[i].e_st == 2'd2) ? 1 : 0;
      exp_hc  = exp_hit ? int'(tbl[i].e_cnt) : 0;
      chk("state",     i, int'(state),         int'(tbl[i].e_st));
      chk("cnt",       i, int'(cnt),           int'(tbl[i].e_cnt));
      chk("n_cnt",     i, int'(n_cnt),         int'(tbl[i].e_ncnt));
      chk("hit",       i, int'(bus.hit),       exp_hit);
      chk("hit_count", i, int'(bus.hit_count), exp_hc);
      chk("sat",       i, int'(bus.sat),       0);
      chk("drop",      i, int'(bus.drop),      int'(tbl[i].e_drop));
      tick();
    end

    // Saturation: mask=0, 20 beats, count stops at 15
    bus.abort = 1'b0; bus.mode = 1'b0; bus.hit_ready = 1'b0;
    bus.pattern = 4'h5; bus.mask = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      bus.valid = 1'b1;
      bus.seq   = 4'(k);
      tick();
      chk("sat_cnt",  k, int'(cnt),     (k > 15) ? 15 : k);
      chk("sat_flag", k, int'(bus.sat), (k >= 16) ? 1 : 0);
    end
    bus.valid = 1'b0;
    bus.hit_ready = 1'b1;
    tick();
    chk("sat_emit_state", 0, int'(state),   2);
    chk("sat_emit_sat",   0, int'(bus.sat), 1);
    hs = 0;
    for (int i = 0; i < 40 && state == 2'd2; i++) begin
      chk("sat_hc", hs, int'(bus.hit_count), 15 - hs);
      if (bus.hit && bus.hit_ready) hs++;
      tick();
    end
    chk("sat_handshakes", 0, hs, 15);
    chk("sat_idle_state", 0, int'(state),   0);
    chk("sat_idle_sat",   0, int'(bus.sat), 0);
    chk("sat_idle_hit",   0, int'(bus.hit), 0);

    // Asynchronous reset in the middle of EMIT, between clock edges
    bus.hit_ready = 1'b0; bus.mask = 4'hF; bus.pattern = 4'hA; bus.seq = 4'hA;
    bus.valid = 1'b1;
    tick();
    tick();
    bus.valid = 1'b0;
    tick();
    chk("ar_pre_state", 0, int'(state),   2);
    chk("ar_pre_hc",    0, int'(bus.hit_count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_state", 0, int'(state),         0);
    chk("ar_cnt",   0, int'(cnt),           0);
    chk("ar_hit",   0, int'(bus.hit),       0);
    chk("ar_hc",    0, int'(bus.hit_count), 0);
    #3;
    reset = 1'b0;
    tick();
    chk("ar_post_state", 0, int'(state),   0);
    chk("ar_post_hit",   0, int'(bus.hit), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
